// File: rtl/sample_uart_tx.sv
// sample_uart_tx: streams DEPTH 12-bit samples out of a sample buffer over an
// 8N1 UART line. Each word goes out as two bytes, high nibble byte first,
// back to back. Consecutive words are separated by the two-cycle
// fetch/latch gap.
module sample_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 512,
    parameter int ADDR_W       = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tx_en,
    input  logic [11:0]       i_read_data,
    output logic [ADDR_W-1:0] o_read_address,
    output logic              o_read_en,
    output logic              o_uart_tx,
    output logic              o_tx_ready,
    output logic              o_done
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP,
        DONE
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;       // cycles within the current bit
    logic [3:0]          bit_idx_q,  bit_idx_d;   // data bit being sent
    logic                byte_sel_q, byte_sel_d;  // 0: high byte, 1: low byte
    logic [11:0]         word_q,     word_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic                read_en_q,  read_en_d;
    logic                tx_q,       tx_d;
    logic                ready_q,    ready_d;
    logic                done_q,     done_d;

    logic [7:0]          cur_byte;
    logic                bit_end;
    logic [2:0]          next_idx;

    // Next-state and registered-output logic for the transmit sequencer.
    always_comb begin
        // NOTE: every _d gets a default up front so no path through the case
        // leaves a signal unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        addr_d     = addr_q;
        read_en_d  = read_en_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        cur_byte = byte_sel_q ? word_q[7:0] : {4'b0000, word_q[11:8]};
        bit_end  = (cnt_q == CNT_LAST);
        next_idx = bit_idx_q[2:0] + 3'd1;

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                ready_d   = 1'b1;
                read_en_d = 1'b0;
                cnt_d     = '0;
                bit_idx_d = '0;
                if (i_tx_en) begin
                    state_d   = FETCH;
                    read_en_d = 1'b1;
                    addr_d    = '0;
                    ready_d   = 1'b0;
                end
            end

            // Buffer is reading the word this cycle.
            FETCH: begin
                read_en_d = 1'b0;
                state_d   = LATCH;
            end

            // Read data is valid now; capture it and open the start bit.
            LATCH: begin
                word_d     = i_read_data;
                byte_sel_d = 1'b0;
                cnt_d      = '0;
                tx_d       = 1'b0;
                state_d    = START;
            end

            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = cur_byte[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd7) begin
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = cur_byte[next_idx];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // The line stays high across the fetch/latch gap and into DONE.
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else if (addr_q < ADDR_LAST) begin
                        addr_d    = addr_q + 1'b1;
                        read_en_d = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset forces the idle line level and aborts any frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            word_q     <= '0;
            addr_q     <= '0;
            read_en_q  <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            read_en_q  <= read_en_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign o_read_address = addr_q;
    assign o_read_en      = read_en_q;
    assign o_uart_tx      = tx_q;
    assign o_tx_ready     = ready_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Bench for sample_uart_tx: two instances (DEPTH=1 and DEPTH=4, 4 clocks per
// bit). Each cycle the outputs are logged on the falling edge. A receiver
// model then decodes the log and checks bit timing, byte values, read strobes
// and handshakes against hand-computed values.
module tb_sample_uart_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic       tx;
        logic       rd;
        logic [1:0] addr;
        logic       done;
        logic       rdy;
    } smp_t;

    logic        clk;
    logic        rst_n;
    logic        tx_en_a, tx_en_b;
    logic [11:0] rdata_a, rdata_b;
    logic [0:0]  addr_a;
    logic [1:0]  addr_b;
    logic        rd_a, rd_b, tx_a, tx_b, rdy_a, rdy_b, done_a, done_b;

    logic [11:0] mem_a0;
    logic [11:0] mem_b [4];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cur      = 0;
    smp_t log_q[$];

    int          dec_start [16];
    logic [7:0]  dec_byte  [16];
    logic        dec_ok    [16];

    logic [7:0]  exp_full [8] = '{8'h00, 8'h00, 8'h0F, 8'hFF, 8'h08, 8'h01, 8'h01, 8'h7E};

    sample_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(1), .ADDR_W(1)) dut_a (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tx_en        (tx_en_a),
        .i_read_data    (rdata_a),
        .o_read_address (addr_a),
        .o_read_en      (rd_a),
        .o_uart_tx      (tx_a),
        .o_tx_ready     (rdy_a),
        .o_done         (done_a)
    );

    sample_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(4), .ADDR_W(2)) dut_b (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tx_en        (tx_en_b),
        .i_read_data    (rdata_b),
        .o_read_address (addr_b),
        .o_read_en      (rd_b),
        .o_uart_tx      (tx_b),
        .o_tx_ready     (rdy_b),
        .o_done         (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample buffers: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_a) rdata_a <= mem_a0;
        if (rd_b) rdata_b <= mem_b[addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one cycle and log the selected instance's outputs.
    task automatic step();
        smp_t s;
        @(negedge clk);
        if (cur == 0) s = '{tx: tx_a, rd: rd_a, addr: {1'b0, addr_a}, done: done_a, rdy: rdy_a};
        else          s = '{tx: tx_b, rd: rd_b, addr: addr_b,          done: done_b, rdy: rdy_b};
        log_q.push_back(s);
    endtask

    // Receiver model: find each start bit and require every bit to hold a
    // constant level for exactly CPB logged cycles.
    task automatic decode(input int nbytes);
        int   i;
        logic v;
        i = 0;
        for (int b = 0; b < 16; b++) begin
            dec_start[b] = -1;
            dec_byte[b]  = 8'h00;
            dec_ok[b]    = 1'b0;
        end
        for (int b = 0; b < nbytes; b++) begin
            while (i < log_q.size() && log_q[i].tx !== 1'b0) i++;
            if (i + 10 * CPB > log_q.size()) break;
            dec_start[b] = i;
            dec_ok[b]    = 1'b1;
            for (int k = 0; k < 10; k++) begin
                v = log_q[i + k * CPB].tx;
                for (int c = 1; c < CPB; c++)
                    if (log_q[i + k * CPB + c].tx !== v) dec_ok[b] = 1'b0;
                if (k == 0 && v !== 1'b0) dec_ok[b] = 1'b0;
                if (k == 9 && v !== 1'b1) dec_ok[b] = 1'b0;
                if (k >= 1 && k <= 8) dec_byte[b][k-1] = v;
            end
            i += 10 * CPB;
        end
    endtask

    // Checks for one DEPTH=4 transfer of the words 000, FFF, 801, 17E.
    task automatic check_full(input string pfx);
        int n_rd;
        int n_done;
        decode(8);
        for (int b = 0; b < 8; b++) begin
            check($sformatf("%s byte%0d", pfx, b), 32'(dec_byte[b]), 32'(exp_full[b]));
            check($sformatf("%s frame%0d", pfx, b), 32'(dec_ok[b]), 32'd1);
            check($sformatf("%s start%0d", pfx, b), 32'(dec_start[b]), 32'(3 + 82 * (b / 2) + 40 * (b % 2)));
        end
        n_rd   = 0;
        n_done = 0;
        for (int i = 1; i <= 330; i++) begin
            if (log_q[i].rd === 1'b1) begin
                check($sformatf("%s rd_addr%0d", pfx, n_rd), 32'(log_q[i].addr), 32'(n_rd));
                check($sformatf("%s rd_at%0d", pfx, n_rd), 32'(i), 32'(1 + 82 * n_rd));
                n_rd++;
            end
            if (log_q[i].done === 1'b1) n_done++;
        end
        check({pfx, " rd_pulses"}, 32'(n_rd), 32'd4);
        check({pfx, " done_pulses"}, 32'(n_done), 32'd1);
        check({pfx, " done_at"}, 32'(log_q[329].done), 32'd1);
        check({pfx, " gap_hi"}, 32'({log_q[83].tx, log_q[84].tx}), 32'd3);
        check({pfx, " ready_back"}, 32'(log_q[330].rdy), 32'd1);
        check({pfx, " addr_held"}, 32'(log_q[330].addr), 32'd3);
    endtask

    initial begin
        int n_low;
        int n_rd;
        int n_rdy;

        rst_n   = 1'b1;
        tx_en_a = 1'b0;
        tx_en_b = 1'b0;
        mem_a0  = 12'hA5C;
        mem_b[0] = 12'h000;
        mem_b[1] = 12'hFFF;
        mem_b[2] = 12'h801;
        mem_b[3] = 12'h17E;

        // Reset applied between edges takes effect without a clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst tx",    32'(tx_b),   32'd1);
        check("rst ready", 32'(rdy_b),  32'd1);
        check("rst rd",    32'(rd_b),   32'd0);
        check("rst done",  32'(done_b), 32'd0);
        check("rst addr",  32'(addr_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no request: line high, ready, no reads.
        cur = 1;
        log_q.delete();
        repeat (5) step();
        check("idle tx",    32'({log_q[4].tx, log_q[4].rdy, log_q[4].rd}), 32'b110);

        // Single word on the DEPTH=1 instance.
        cur = 0;
        log_q.delete();
        step();
        tx_en_a = 1'b1;
        step();
        tx_en_a = 1'b0;
        repeat (90) step();
        check("one accept_rd",    32'(log_q[1].rd),   32'd1);
        check("one accept_addr",  32'(log_q[1].addr), 32'd0);
        check("one accept_ready", 32'(log_q[1].rdy),  32'd0);
        check("one fetch_rd",     32'(log_q[2].rd),   32'd0);
        decode(2);
        check("one byte0",  32'(dec_byte[0]),  32'h0A);
        check("one byte1",  32'(dec_byte[1]),  32'h5C);
        check("one frame0", 32'(dec_ok[0]),    32'd1);
        check("one frame1", 32'(dec_ok[1]),    32'd1);
        check("one start0", 32'(dec_start[0]), 32'd3);
        check("one start1", 32'(dec_start[1]), 32'd43);
        check("one done",   32'({log_q[82].done, log_q[83].done, log_q[84].done}), 32'b010);
        check("one ready",  32'({log_q[83].rdy, log_q[84].rdy}), 32'b01);

        // Full four-word transfer, request pulsed once.
        cur = 1;
        log_q.delete();
        step();
        tx_en_b = 1'b1;
        step();
        tx_en_b = 1'b0;
        repeat (335) step();
        check_full("full");

        // Request toggled mid-byte and held high through DONE.
        log_q.delete();
        step();
        tx_en_b = 1'b1;
        for (int c = 1; c <= 331; c++) begin
            step();
            if (c >= 10 && c <= 40) tx_en_b = c[0];
            else                    tx_en_b = 1'b1;
        end
        tx_en_b = 1'b0;
        check_full("busy");
        n_rdy = 0;
        for (int i = 1; i <= 330; i++)
            if (log_q[i].rdy === 1'b1) n_rdy++;
        check("busy ready_cycles", 32'(n_rdy), 32'd1);
        check("busy restart_rd",   32'(log_q[331].rd),   32'd1);
        check("busy restart_addr", 32'(log_q[331].addr), 32'd0);

        // Reset during data bit 3 of the second byte of the restarted transfer.
        for (int c = 332; c <= 390; c++) step();
        check("mid restart_start", 32'(log_q[333].tx), 32'd0);
        check("mid line_low",      32'(log_q[390].tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid tx",    32'(tx_b),   32'd1);
        check("mid addr",  32'(addr_b), 32'd0);
        check("mid ready", 32'(rdy_b),  32'd1);
        check("mid rd",    32'(rd_b),   32'd0);
        check("mid done",  32'(done_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No resumption after release without a new request.
        log_q.delete();
        repeat (60) step();
        n_low = 0;
        n_rd  = 0;
        for (int i = 0; i < 60; i++) begin
            if (log_q[i].tx !== 1'b1) n_low++;
            if (log_q[i].rd !== 1'b0) n_rd++;
        end
        check("post low_cycles", 32'(n_low), 32'd0);
        check("post rd_cycles",  32'(n_rd),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
